// File: rtl/net_pkg.sv
// -----------------------------------------------------------------------------
// net_pkg
// Shared constants and types for the network transmit framer.
//   DATA_SIZE_DEF / TAG_SIZE_DEF : default host data and tag widths
//   DROP_CNT_W                   : width of the saturating drop counter
//   ndt_word_t                   : network word {data, tag} at default widths
//   ndt_word_parity()            : even parity (XOR) of a default-width word
// -----------------------------------------------------------------------------
package net_pkg;

  localparam int DATA_SIZE_DEF = 32;
  localparam int TAG_SIZE_DEF  = 8;
  localparam int DROP_CNT_W    = 8;
  localparam int NDT_W_DEF     = DATA_SIZE_DEF + TAG_SIZE_DEF;

  typedef logic [NDT_W_DEF-1:0] ndt_word_t;

  function automatic logic ndt_word_parity(input ndt_word_t w);
    return ^w;
  endfunction

endpackage

// File: rtl/ndt_fifo.sv
// -----------------------------------------------------------------------------
// ndt_fifo
// Synchronous FIFO holding framed network words for net_tx_framer.
//   clk, reset (async, active-low)
//   push / din   : write request and data (ignored when full)
//   pop          : read request (ignored when empty)
//   dout         : head entry, forced to 0 while empty
//   count        : occupancy, 0..DEPTH
//   empty / full : occupancy flags, derived from registered count only
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module ndt_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);
  import net_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    // Push and pop together leave occupancy unchanged.
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = empty ? '0 : mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/net_tx_framer.sv
// -----------------------------------------------------------------------------
// net_tx_framer
// Frames host data words into network (NDT) words {data, tag} and buffers them.
//   clk, reset (async, active-low)
//   tx_valid / tx_ready / tx_data / soft_error_in : host side
//   ndt_valid / ndt_ready / ndt_out               : network side
//   fifo_count : buffer occupancy
//   drop_count : saturating count of words dropped for soft error
// Optional build macro NET_TX_PARITY_EN adds ndt_parity, the even parity of the
// head word, computed once at push time and stored alongside the entry.
// -----------------------------------------------------------------------------
module net_tx_framer
  import net_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int TAG_SIZE  = TAG_SIZE_DEF,
  parameter int DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic [DATA_SIZE-1:0]          tx_data,
  input  logic                          soft_error_in,
  output logic                          ndt_valid,
  input  logic                          ndt_ready,
  output logic [DATA_SIZE+TAG_SIZE-1:0] ndt_out,
  output logic [$clog2(DEPTH):0]        fifo_count,
  output logic [DROP_CNT_W-1:0]         drop_count
`ifdef NET_TX_PARITY_EN
  ,
  output logic                          ndt_parity
`endif
);

  localparam int NDT_W = DATA_SIZE + TAG_SIZE;
`ifdef NET_TX_PARITY_EN
  localparam int FIFO_W = NDT_W + 1;
`else
  localparam int FIFO_W = NDT_W;
`endif

  logic [TAG_SIZE-1:0]   tag_q, tag_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;
  // Holds tx_ready low through reset and until the first edge after release.
  logic                  run_q, run_d;

  logic                  accept;
  logic                  push;
  logic                  pop;
  logic [NDT_W-1:0]      word;
  logic [FIFO_W-1:0]     fifo_din;
  logic [FIFO_W-1:0]     fifo_dout;
  logic                  fifo_empty;
  logic                  fifo_full;

  // tx_ready depends only on registered state, never on ndt_ready.
  assign tx_ready  = run_q && !fifo_full;
  assign ndt_valid = !fifo_empty;

  assign accept = tx_valid && tx_ready;
  assign push   = accept && !soft_error_in;
  assign pop    = ndt_valid && ndt_ready;
  assign word   = {tx_data, tag_q};

`ifdef NET_TX_PARITY_EN
  assign fifo_din   = {^word, word};
  assign ndt_out    = fifo_dout[NDT_W-1:0];
  assign ndt_parity = fifo_dout[NDT_W];
`else
  assign fifo_din   = word;
  assign ndt_out    = fifo_dout;
`endif

  always_comb begin
    tag_d  = tag_q;
    drop_d = drop_q;
    run_d  = 1'b1;
    if (push) begin
      tag_d = tag_q + TAG_SIZE'(1);
    end
    if (accept && soft_error_in && (drop_q != '1)) begin
      drop_d = drop_q + DROP_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_q  <= '0;
      drop_q <= '0;
      run_q  <= 1'b0;
    end else begin
      tag_q  <= tag_d;
      drop_q <= drop_d;
      run_q  <= run_d;
    end
  end

  assign drop_count = drop_q;

  ndt_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

endmodule

// File: tb/tb_net_tx_framer.sv
// -----------------------------------------------------------------------------
// tb_net_tx_framer
// Directed testbench for net_tx_framer at default parameters (32/8/4).
// Inputs are driven 1 ns after each rising edge and outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_net_tx_framer;
  import net_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] tx_data;
  logic        soft_error_in;
  logic        ndt_valid;
  logic        ndt_ready;
  logic [39:0] ndt_out;
  logic [2:0]  fifo_count;
  logic [7:0]  drop_count;
`ifdef NET_TX_PARITY_EN
  logic        ndt_parity;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  net_tx_framer #(
    .DATA_SIZE (32),
    .TAG_SIZE  (8),
    .DEPTH     (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .tx_data       (tx_data),
    .soft_error_in (soft_error_in),
    .ndt_valid     (ndt_valid),
    .ndt_ready     (ndt_ready),
    .ndt_out       (ndt_out),
    .fifo_count    (fifo_count),
    .drop_count    (drop_count)
`ifdef NET_TX_PARITY_EN
    ,
    .ndt_parity    (ndt_parity)
`endif
  );

  task automatic check_val(input string tag, input logic [63:0] obs,
                           input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tx_valid      = 1'b0;
    soft_error_in = 1'b0;
    tx_data       = '0;
    ndt_ready     = 1'b0;
    reset         = 1'b0;
    #3;
    check_val("rst_count", 64'(fifo_count), 64'd0);
    check_val("rst_valid", 64'(ndt_valid), 64'd0);
    check_val("rst_out",   64'(ndt_out), 64'd0);
    check_val("rst_ready", 64'(tx_ready), 64'd0);
    check_val("rst_drop",  64'(drop_count), 64'd0);
    step();
    reset = 1'b1;
    #1;
    check_val("rel_ready_pre", 64'(tx_ready), 64'd0);
    step();
    check_val("rel_ready_post", 64'(tx_ready), 64'd1);
  endtask

  initial begin
    reset         = 1'b0;
    tx_valid      = 1'b0;
    soft_error_in = 1'b0;
    tx_data       = '0;
    ndt_ready     = 1'b0;

    // Single word, one cycle latency, tag 00.
    do_reset();
    tx_valid  = 1'b1;
    tx_data   = 32'hDEADBEEF;
    ndt_ready = 1'b1;
    check_val("no_bypass_valid", 64'(ndt_valid), 64'd0);
    step();
    tx_valid = 1'b0;
    check_val("first_valid", 64'(ndt_valid), 64'd1);
    check_val("first_out", 64'(ndt_out), 64'hDEADBEEF00);
    step();
    check_val("first_gone", 64'(ndt_valid), 64'd0);

    // Fill to full with the network stalled, then drain in order.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tx_valid = 1'b1;
      tx_data  = 32'h100 + 32'(i);
      step();
      if (i == 3) begin
        check_val("full_ready", 64'(tx_ready), 64'd0);
        check_val("full_count", 64'(fifo_count), 64'd4);
      end
    end
    check_val("full_hold_count", 64'(fifo_count), 64'd4);
    check_val("stall_out", 64'(ndt_out), {24'd0, 32'h100, 8'h00});
    step();
    check_val("stall_hold_out", 64'(ndt_out), {24'd0, 32'h100, 8'h00});
    tx_valid  = 1'b0;
    ndt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_val("drain_out", 64'(ndt_out), {24'd0, 32'h100 + 32'(i), 8'(i)});
      step();
      if (i == 0) check_val("pop_full_ready", 64'(tx_ready), 64'd1);
    end
    check_val("drain_empty", 64'(ndt_valid), 64'd0);

    // Soft-error word is dropped and does not consume a tag.
    do_reset();
    tx_valid      = 1'b1;
    soft_error_in = 1'b1;
    tx_data       = 32'hAAAA0000;
    step();
    check_val("soft_no_emit", 64'(ndt_valid), 64'd0);
    check_val("soft_drop", 64'(drop_count), 64'd1);
    soft_error_in = 1'b0;
    tx_data       = 32'h00005555;
    step();
    tx_valid = 1'b0;
    check_val("clean_after_soft", 64'(ndt_out), {24'd0, 32'h00005555, 8'h00});
    ndt_ready = 1'b1;
    step();
    check_val("soft_drained", 64'(fifo_count), 64'd0);

    // Tag wrap over 257 clean words, then drop counter saturation.
    do_reset();
    ndt_ready = 1'b1;
    for (int k = 0; k < 257; k++) begin
      tx_valid = 1'b1;
      tx_data  = 32'(k);
      step();
      if (k == 255) check_val("tag_ff", 64'(ndt_out), {24'd0, 32'd255, 8'hFF});
    end
    tx_valid = 1'b0;
    check_val("tag_wrap", 64'(ndt_out), {24'd0, 32'd256, 8'h00});
    step();
    tx_valid      = 1'b1;
    soft_error_in = 1'b1;
    for (int k = 0; k < 256; k++) begin
      step();
      if (k == 254) check_val("drop_255", 64'(drop_count), 64'd255);
    end
    check_val("drop_sat", 64'(drop_count), 64'd255);
    check_val("drop_no_push", 64'(ndt_valid), 64'd0);
    tx_valid      = 1'b0;
    soft_error_in = 1'b0;

    // Steady push+pop at occupancy 2, then asynchronous reset mid-stream.
    do_reset();
    tx_valid = 1'b1;
    tx_data  = 32'h10;
    step();
    tx_data = 32'h11;
    step();
    check_val("pre_stream_count", 64'(fifo_count), 64'd2);
    ndt_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tx_data = 32'h12 + 32'(i);
      check_val("stream_out", 64'(ndt_out), {24'd0, 32'h10 + 32'(i), 8'(i)});
      step();
      check_val("stream_count", 64'(fifo_count), 64'd2);
    end
    #2;
    reset = 1'b0;
    #1;
    check_val("async_valid", 64'(ndt_valid), 64'd0);
    check_val("async_count", 64'(fifo_count), 64'd0);
    check_val("async_ready", 64'(tx_ready), 64'd0);
    tx_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    check_val("post_async_ready", 64'(tx_ready), 64'd1);
    check_val("post_async_valid", 64'(ndt_valid), 64'd0);

`ifdef NET_TX_PARITY_EN
    do_reset();
    check_val("par_rst", 64'(ndt_parity), 64'd0);
    tx_valid = 1'b1;
    tx_data  = 32'h00000001;
    step();
    tx_data = 32'h00000003;
    step();
    tx_valid = 1'b0;
    check_val("par_one", 64'(ndt_parity), 64'd1);
    ndt_ready = 1'b1;
    step();
    // 0x00000003 with tag 0x01 has three set bits.
    check_val("par_two", 64'(ndt_parity), 64'd1);
    check_val("par_two_out", 64'(ndt_out), {24'd0, 32'h3, 8'h01});
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
